// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq
//   Multi-cycle sequencer for unsigned WIDTH-bit MUL (low word) and DIVU/REMU.
//   It does not own an adder: every arithmetic step is issued to the shared
//   datapath ALU through o_alu_a/o_alu_b/o_alu_sel, and the result comes back
//   on i_alu_res/i_alu_zero in the same cycle.
//     sel 000 = add, 001 = sub, 100 = unsigned set-less-than.
//   MUL : shift-add, one ALU add per multiplier bit.
//   DIVU: restoring divide, one compare per bit plus a subtract when the
//         partial remainder is >= divisor.
// Ports
//   i_clk, i_rst        clock / synchronous active-high reset
//   i_start, i_op       launch request (IDLE only), 0 = MUL, 1 = DIVU
//   i_opa, i_opb        multiplicand/dividend, multiplier/divisor
//   o_alu_a/b/sel       ALU operand and function drive (zero when not busy)
//   i_alu_res/zero      ALU result and zero flag
//   o_busy              high while iterating
//   o_done              one-cycle completion pulse
//   o_res_lo/hi         product low word & 0, or quotient & remainder
module alu_muldiv_seq #(
  parameter int WIDTH      = 32,
  parameter int EARLY_TERM = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_op,
  input  logic [WIDTH-1:0] i_opa,
  input  logic [WIDTH-1:0] i_opb,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  output logic [2:0]       o_alu_sel,
  input  logic [WIDTH-1:0] i_alu_res,
  input  logic             i_alu_zero,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_res_lo,
  output logic [WIDTH-1:0] o_res_hi
);

  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);
  localparam logic [2:0]      SEL_ADD  = 3'b000;
  localparam logic [2:0]      SEL_SUB  = 3'b001;
  localparam logic [2:0]      SEL_SLTU = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV_CMP,
    S_DIV_SUB,
    S_DONE
  } state_t;

  state_t r_state, w_state_nxt;

  // Operand registers are shared between the two operations:
  //   r_x   : multiplicand (MUL) / quotient-dividend shift register (DIVU)
  //   r_y   : multiplier   (MUL) / divisor (DIVU)
  //   r_acc : product accumulator (MUL) / partial remainder (DIVU)
  logic [WIDTH-1:0] r_x, r_y, r_acc;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_res_lo, r_res_hi;

  logic [WIDTH-1:0] w_rem_sh;
  logic [WIDTH-1:0] w_mplr_sh;
  logic [WIDTH-1:0] w_acc_mul;
  logic [WIDTH-1:0] w_quo_sh;
  logic             w_cnt_last;
  logic             w_mul_fin;
  logic             w_ge;
  logic             w_opb_zero;

  assign w_rem_sh   = {r_acc[WIDTH-2:0], r_x[WIDTH-1]};
  assign w_quo_sh   = {r_x[WIDTH-2:0], 1'b0};
  assign w_mplr_sh  = r_y >> 1;
  assign w_acc_mul  = r_y[0] ? i_alu_res : r_acc;
  assign w_cnt_last = (r_cnt == CNT_LAST);
  assign w_opb_zero = (i_opb == '0);
  // Early exit once no set multiplier bits remain above the current one.
  assign w_mul_fin  = w_cnt_last || ((EARLY_TERM != 0) && (w_mplr_sh == '0));
  // The bit shifted out of the remainder makes the true value >= 2^WIDTH,
  // which always exceeds the divisor; otherwise trust the SLTU result.
  assign w_ge       = r_acc[WIDTH-1] | i_alu_zero;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and ALU drive
  always_comb begin
    w_state_nxt = r_state;
    o_alu_a     = '0;
    o_alu_b     = '0;
    o_alu_sel   = SEL_ADD;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (!i_op)
            w_state_nxt = ((EARLY_TERM != 0) && w_opb_zero) ? S_DONE : S_MUL;
          else
            w_state_nxt = w_opb_zero ? S_DONE : S_DIV_CMP;
        end
      end
      S_MUL: begin
        o_alu_a   = r_acc;
        o_alu_b   = r_x;
        o_alu_sel = SEL_ADD;
        if (w_mul_fin) w_state_nxt = S_DONE;
      end
      S_DIV_CMP: begin
        o_alu_a   = w_rem_sh;
        o_alu_b   = r_y;
        o_alu_sel = SEL_SLTU;
        if (w_ge)            w_state_nxt = S_DIV_SUB;
        else if (w_cnt_last) w_state_nxt = S_DONE;
        else                 w_state_nxt = S_DIV_CMP;
      end
      S_DIV_SUB: begin
        o_alu_a     = r_acc;
        o_alu_b     = r_y;
        o_alu_sel   = SEL_SUB;
        w_state_nxt = w_cnt_last ? S_DONE : S_DIV_CMP;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath. Results are loaded only on the transition into DONE, using the
  // same next-values the iteration registers receive on that edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_x      <= '0;
      r_y      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_res_lo <= '0;
      r_res_hi <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_x   <= i_opa;
            r_y   <= i_opb;
            r_acc <= '0;
            r_cnt <= '0;
            if (i_op && w_opb_zero) begin
              r_res_lo <= '1;
              r_res_hi <= i_opa;
            end else if (!i_op && (EARLY_TERM != 0) && w_opb_zero) begin
              r_res_lo <= '0;
              r_res_hi <= '0;
            end
          end
        end
        S_MUL: begin
          r_acc <= w_acc_mul;
          r_x   <= r_x << 1;
          r_y   <= w_mplr_sh;
          r_cnt <= r_cnt + 1'b1;
          if (w_mul_fin) begin
            r_res_lo <= w_acc_mul;
            r_res_hi <= '0;
          end
        end
        S_DIV_CMP: begin
          r_acc <= w_rem_sh;
          r_x   <= w_quo_sh;
          if (!w_ge) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_cnt_last) begin
              r_res_lo <= w_quo_sh;
              r_res_hi <= w_rem_sh;
            end
          end
        end
        S_DIV_SUB: begin
          r_acc  <= i_alu_res;
          r_x[0] <= 1'b1;
          r_cnt  <= r_cnt + 1'b1;
          if (w_cnt_last) begin
            r_res_lo <= {r_x[WIDTH-1:1], 1'b1};
            r_res_hi <= i_alu_res;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy   = (r_state == S_MUL) || (r_state == S_DIV_CMP) || (r_state == S_DIV_SUB);
  assign o_done   = (r_state == S_DONE);
  assign o_res_lo = r_res_lo;
  assign o_res_hi = r_res_hi;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Scoreboard bench for alu_muldiv_seq. Two instances: u_et (EARLY_TERM=1)
// and u_ne (EARLY_TERM=0), each with its own behavioural ALU. Stimulus pushes
// expected {lo, hi, done cycle}; a negedge monitor pops on every done pulse.
module tb_alu_muldiv_seq;
  localparam int W = 32;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    int           cyc;
    string        name;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         start [2];
  logic         op    [2];
  logic [W-1:0] opa   [2];
  logic [W-1:0] opb   [2];
  logic [W-1:0] alu_a [2];
  logic [W-1:0] alu_b [2];
  logic [2:0]   alu_sel [2];
  logic [W-1:0] alu_res [2];
  logic         alu_zero [2];
  logic         busy [2];
  logic         done [2];
  logic [W-1:0] res_lo [2];
  logic [W-1:0] res_hi [2];

  exp_t q0[$];
  exp_t q1[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] alu_f(input logic [2:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
    case (s)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b100:  return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  assign alu_res[0]  = alu_f(alu_sel[0], alu_a[0], alu_b[0]);
  assign alu_res[1]  = alu_f(alu_sel[1], alu_a[1], alu_b[1]);
  assign alu_zero[0] = (alu_res[0] == '0);
  assign alu_zero[1] = (alu_res[1] == '0);

  alu_muldiv_seq #(.WIDTH(W), .EARLY_TERM(1)) u_et (
    .i_clk(clk), .i_rst(rst), .i_start(start[0]), .i_op(op[0]),
    .i_opa(opa[0]), .i_opb(opb[0]),
    .o_alu_a(alu_a[0]), .o_alu_b(alu_b[0]), .o_alu_sel(alu_sel[0]),
    .i_alu_res(alu_res[0]), .i_alu_zero(alu_zero[0]),
    .o_busy(busy[0]), .o_done(done[0]), .o_res_lo(res_lo[0]), .o_res_hi(res_hi[0])
  );

  alu_muldiv_seq #(.WIDTH(W), .EARLY_TERM(0)) u_ne (
    .i_clk(clk), .i_rst(rst), .i_start(start[1]), .i_op(op[1]),
    .i_opa(opa[1]), .i_opb(opb[1]),
    .o_alu_a(alu_a[1]), .o_alu_b(alu_b[1]), .o_alu_sel(alu_sel[1]),
    .i_alu_res(alu_res[1]), .i_alu_zero(alu_zero[1]),
    .o_busy(busy[1]), .o_done(done[1]), .o_res_lo(res_lo[1]), .o_res_hi(res_hi[1])
  );

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic mon(input int i);
    exp_t e;
    logic sel_ok;
    if (done[i] === 1'b1) begin
      if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done dut%0d: got done=1, expected no done (cycle %0d)", i, cyc);
      end else begin
        if (i == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        check({e.name, "_lo"}, res_lo[i], e.lo);
        check({e.name, "_hi"}, res_hi[i], e.hi);
        check({e.name, "_cyc"}, cyc, e.cyc);
      end
    end
    // ALU drive legality: only add/sub/sltu while busy, all-zero otherwise.
    if (busy[i] === 1'b1) begin
      sel_ok = (alu_sel[i] == 3'b000) || (alu_sel[i] == 3'b001) || (alu_sel[i] == 3'b100);
      check($sformatf("sel_legal%0d", i), {31'd0, sel_ok}, 32'd1);
    end else begin
      check($sformatf("alu_idle%0d", i), alu_a[i] | alu_b[i] | {29'd0, alu_sel[i]}, 32'd0);
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  // Issue one operation; done is expected at cycle (now + lat), where the
  // accepting edge counts as cycle 1. Operands are scrambled after acceptance.
  task automatic issue(input int i, input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] lo, input logic [W-1:0] hi, input int lat, input string nm);
    exp_t e;
    @(negedge clk); #1;
    e.lo = lo; e.hi = hi; e.cyc = cyc + lat; e.name = nm;
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
    start[i] = 1'b1; op[i] = o; opa[i] = a; opb[i] = b;
    @(posedge clk); #1;
    start[i] = 1'b0; op[i] = ~o; opa[i] = $urandom; opb[i] = $urandom;
  endtask

  task automatic wait_idle(input int i);
    for (int k = 0; k < 100; k++) begin
      if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) break;
      @(negedge clk); #1;
    end
    if ((i == 0 && q0.size() != 0) || (i == 1 && q1.size() != 0)) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout dut%0d: no done pulse within 100 cycles", i);
      if (i == 0) q0.delete();
      else        q1.delete();
    end
  endtask

  task automatic run(input int i, input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] lo, input logic [W-1:0] hi, input int lat, input string nm);
    issue(i, o, a, b, lo, hi, lat, nm);
    wait_idle(i);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; op[i] = 1'b0; opa[i] = '0; opb[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",   {31'd0, busy[0]}, 32'd0);
    check("rst_done",   {31'd0, done[0]}, 32'd0);
    check("rst_res_lo", res_lo[0], 32'd0);
    check("rst_res_hi", res_hi[0], 32'd0);
    check("rst_alu",    alu_a[0] | alu_b[0] | {29'd0, alu_sel[0]}, 32'd0);
    rst = 1'b0;

    // Early-terminating multiplier
    run(0, 1'b0, 32'd7,        32'd6,          32'd42,         32'd0, 4,  "mul_7x6_et");
    run(0, 1'b0, 32'd9,        32'd1,          32'd9,          32'd0, 2,  "mul_9x1_et");
    run(0, 1'b0, 32'h12345678, 32'h10,         32'h23456780,   32'd0, 6,  "mul_x10_et");
    run(0, 1'b0, 32'd123,      32'd0,          32'd0,          32'd0, 1,  "mul_x0_et");
    run(0, 1'b0, 32'd3,        32'h80000000,   32'h80000000,   32'd0, 33, "mul_msb_et");
    // Full-length multiplier
    run(1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF,   32'h00000001,   32'd0, 33, "mul_ffff_ne");
    run(1, 1'b0, 32'd7,        32'd6,          32'd42,         32'd0, 33, "mul_7x6_ne");
    // Divide
    run(0, 1'b1, 32'd100,      32'd7,          32'd14,         32'd2,          36, "div_100_7");
    run(0, 1'b1, 32'hFFFFFFFF, 32'h80000000,   32'd1,          32'h7FFFFFFF,   34, "div_ff_8m");
    run(0, 1'b1, 32'd7,        32'd100,        32'd0,          32'd7,          33, "div_7_100");
    run(0, 1'b1, 32'd1000,     32'd10,         32'd100,        32'd0,          36, "div_1000_10");

    // Divide by zero: completes on the accepting edge, never busy.
    issue(0, 1'b1, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1, "div_5_0");
    check("div0_busy", {31'd0, busy[0]}, 32'd0);
    wait_idle(0);

    // Second start mid-divide must be ignored.
    issue(0, 1'b1, 32'd50, 32'd3, 32'd16, 32'd2, 34, "div_50_3_ign");
    repeat (5) @(negedge clk);
    #1;
    start[0] = 1'b1; op[0] = 1'b0; opa[0] = 32'd1; opb[0] = 32'd1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    wait_idle(0);

    // Reset during a MUL (u_ne still holds 42 from above).
    @(negedge clk); #1;
    start[1] = 1'b1; op[1] = 1'b0; opa[1] = 32'd5; opb[1] = 32'h0000FFFF;
    @(posedge clk); #1;
    start[1] = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstmid_busy",   {31'd0, busy[1]}, 32'd0);
    check("rstmid_done",   {31'd0, done[1]}, 32'd0);
    check("rstmid_res_lo", res_lo[1], 32'd0);
    check("rstmid_res_hi", res_hi[1], 32'd0);
    check("rstmid_alu",    alu_a[1] | alu_b[1] | {29'd0, alu_sel[1]}, 32'd0);
    repeat (40) @(negedge clk);

    // Still functional after the abort.
    run(1, 1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 36, "div_after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
